counter_sweep_ctrl: RTL and testbench
=====================================

# counter_sweep_ctrl

Sequencer for the 8-bit up/down counter: drives the counter's `down` and `rst_n` inputs so the count performs a programmed triangle sweep, ramping from 0 up to `upper`, then oscillating between `upper` and `lower` for `cycles` down-ramps. It watches the counter's `count` output and turns direction early, so the count peaks exactly at `upper` and bottoms exactly at `lower`. It sits between the test/control logic and the counter, and holds the counter in reset whenever no sweep is running.

## Interface
- `WIDTH`, 8: counter width.
- `SWEEP_W`, 4: width of the `cycles` and `sweep_cnt` fields.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous reset, active-high.
- `start` in 1: request a sweep; sampled only in IDLE.
- `abort` in 1: stop the current sweep and return to IDLE.
- `upper` in WIDTH: peak value; latched on start.
- `lower` in WIDTH: trough value; latched on start.
- `cycles` in SWEEP_W: number of down-ramps to perform; latched on start.
- `count` in WIDTH: the counter's `count` output.
- `down` out 1: to counter `down` (registered).
- `cnt_rst_n` out 1: to counter `rst_n`, active-low (registered).
- `busy` out 1: high in UP/DOWN.
- `done` out 1: one-cycle pulse when a sweep completes.
- `err` out 1: one-cycle pulse when start is rejected because of a bad configuration.
- `sweep_cnt` out SWEEP_W: down-ramps completed.

## Operation
- Counter model assumed by this block: on each rising edge, if `rst_n`=0 then count←0; otherwise count←count−1 if `down`=1, else count+1 (mod 2^WIDTH).
- States: IDLE, UP, DOWN, DONE.
- **IDLE**
  - `cnt_rst_n`=0 and `down`=0, so the counter is held at 0.
  - `start`=1 with a valid config: latch `upper`/`lower`/`cycles`, clear `sweep_cnt`, set `cnt_rst_n`←1, `down`←0, go to UP.
  - Valid config means `upper`≥1, `lower`<`upper`, and `cycles`≥1.
  - `start`=1 with an invalid config: `err` pulses for one cycle, stay in IDLE.
- **UP**
  - When sampled `count`==`upper`−1: `down`←1, go to DOWN.
  - The counter reaches `upper` on that same edge.
- **DOWN**
  - When sampled `count`==`lower`+1: `sweep_cnt`←`sweep_cnt`+1. The counter reaches `lower` on that edge.
  - If the new `sweep_cnt`==`cycles`: `cnt_rst_n`←0, `down`←0, go to DONE.
  - Otherwise: `down`←0, go to UP.
- **DONE**
  - `done`=1 for this cycle only, then IDLE.
  - `start` is ignored in DONE.
- **Abort**
  - `abort`=1 in UP or DOWN: `cnt_rst_n`←0, `down`←0, go to IDLE.
  - No `done` pulse; `sweep_cnt` holds its value.
  - `abort` takes priority over a direction turn on the same edge.
- `start` while busy or in DONE is ignored. `abort` in IDLE is ignored.
- Comparisons use the latched config only; input changes mid-sweep have no effect.
- `lower`+1==`upper` is legal: each ramp is one step.
- `sweep_cnt` holds after DONE until the next accepted start.

## Timing
- Reset values: IDLE, `down`=0, `cnt_rst_n`=0, `busy`=0, `done`=0, `err`=0, `sweep_cnt`=0, latched config=0.
- `rst` mid-sweep: all outputs return to their reset values immediately (asynchronously); the counter is cleared on its next edge.
- Let E0 be the edge that accepts `start`.
  - `busy`=1 after E0.
  - The counter's first increment is at E1.
  - The first peak is reached at E`upper`.
- Each later ramp, down or up, takes `upper`−`lower` edges.
- The final `lower` is reached at edge E0 + `upper` + (2·`cycles`−1)·(`upper`−`lower`).
  - `done` is high during the cycle that follows that edge.
  - The counter shows `lower` for one cycle, then 0.
- `err` is asserted in the cycle after the rejecting edge.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset, then `upper`=5, `lower`=2, `cycles`=2, pulse `start`:
  - count sequence 1,2,3,4,5,4,3,2,3,4,5,4,3,2, then 0;
  - `sweep_cnt`=1 after E8 and 2 after E14;
  - `done` high only after E14.
- `upper`=1, `lower`=0, `cycles`=3: count 1,0,1,0,1,0; `done` after E6; `down` toggles every edge.
- Invalid configs (`upper`=3, `lower`=3); (`upper`=0); (`cycles`=0): `err` pulses once each, `busy` stays 0, count stays 0.
- `upper`=10, `lower`=0, `cycles`=4, `abort` at E7: count 7, then 0; no `done`; `sweep_cnt`=0; a following `start` runs normally.
- Assert `rst` mid-DOWN at a non-edge time: `cnt_rst_n`=0, `down`=0, `busy`=0 immediately; count is 0 after the next edge.
- `start` held high through an entire run, including the DONE cycle: no restart until IDLE, then a new sweep begins on the next edge.

Source files
------------

// File: rtl/counter_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : counter_sweep_ctrl
// Purpose  : Drives an up/down counter through a programmed triangle sweep.
// Revision : 1.0
// ============================================================================
module counter_sweep_ctrl #(
   parameter int WIDTH   = 8,
   parameter int SWEEP_W = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               abort,
   input  logic [WIDTH-1:0]   upper,
   input  logic [WIDTH-1:0]   lower,
   input  logic [SWEEP_W-1:0] cycles,
   input  logic [WIDTH-1:0]   count,
   output logic               down,
   output logic               cnt_rst_n,
   output logic               busy,
   output logic               done,
   output logic               err,
   output logic [SWEEP_W-1:0] sweep_cnt
);

   localparam logic [1:0] c_ST_IDLE = 2'd0;
   localparam logic [1:0] c_ST_UP   = 2'd1;
   localparam logic [1:0] c_ST_DOWN = 2'd2;
   localparam logic [1:0] c_ST_DONE = 2'd3;

   localparam logic [WIDTH-1:0]   c_ONE   = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [SWEEP_W-1:0] c_S_ONE = {{(SWEEP_W-1){1'b0}}, 1'b1};

   logic [1:0]         r_state;
   logic [1:0]         w_state_nxt;
   logic [WIDTH-1:0]   r_upper;
   logic [WIDTH-1:0]   r_lower;
   logic [SWEEP_W-1:0] r_cycles;
   logic [SWEEP_W-1:0] r_sweep_cnt;
   logic               r_down;
   logic               r_cnt_rst_n;
   logic               r_err;

   logic               w_down_nxt;
   logic               w_cnt_rst_n_nxt;
   logic               w_err_nxt;
   logic               w_latch;
   logic [SWEEP_W-1:0] w_sweep_cnt_nxt;
   logic [SWEEP_W-1:0] w_sweep_inc;
   logic               w_cfg_ok;
   logic               w_at_peak;
   logic               w_at_trough;
   logic               w_last;

   assign w_cfg_ok    = (upper != '0) && (lower < upper) && (cycles != '0);
   // Turn one step early: the counter lands on the extreme on the same edge.
   assign w_at_peak   = (count == (r_upper - c_ONE));
   assign w_at_trough = (count == (r_lower + c_ONE));
   assign w_sweep_inc = r_sweep_cnt + c_S_ONE;
   assign w_last      = (w_sweep_inc == r_cycles);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= c_ST_IDLE;
         r_upper     <= '0;
         r_lower     <= '0;
         r_cycles    <= '0;
         r_sweep_cnt <= '0;
         r_down      <= 1'b0;
         r_cnt_rst_n <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_sweep_cnt <= w_sweep_cnt_nxt;
         r_down      <= w_down_nxt;
         r_cnt_rst_n <= w_cnt_rst_n_nxt;
         r_err       <= w_err_nxt;
         if (w_latch) begin
            r_upper  <= upper;
            r_lower  <= lower;
            r_cycles <= cycles;
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_ST_IDLE: begin
            if (start && w_cfg_ok) w_state_nxt = c_ST_UP;
         end
         c_ST_UP: begin
            if (abort)          w_state_nxt = c_ST_IDLE;
            else if (w_at_peak) w_state_nxt = c_ST_DOWN;
         end
         c_ST_DOWN: begin
            if (abort)            w_state_nxt = c_ST_IDLE;
            else if (w_at_trough) w_state_nxt = w_last ? c_ST_DONE : c_ST_UP;
         end
         default: w_state_nxt = c_ST_IDLE;
      endcase
   end

   always_comb begin
      w_down_nxt      = r_down;
      w_cnt_rst_n_nxt = r_cnt_rst_n;
      w_err_nxt       = 1'b0;
      w_latch         = 1'b0;
      w_sweep_cnt_nxt = r_sweep_cnt;
      case (r_state)
         c_ST_IDLE: begin
            w_down_nxt      = 1'b0;
            w_cnt_rst_n_nxt = 1'b0;
            if (start) begin
               if (w_cfg_ok) begin
                  w_latch         = 1'b1;
                  w_sweep_cnt_nxt = '0;
                  w_cnt_rst_n_nxt = 1'b1;
               end else begin
                  w_err_nxt = 1'b1;
               end
            end
         end
         c_ST_UP: begin
            if (abort) begin
               w_cnt_rst_n_nxt = 1'b0;
               w_down_nxt      = 1'b0;
            end else if (w_at_peak) begin
               w_down_nxt = 1'b1;
            end
         end
         c_ST_DOWN: begin
            if (abort) begin
               w_cnt_rst_n_nxt = 1'b0;
               w_down_nxt      = 1'b0;
            end else if (w_at_trough) begin
               w_sweep_cnt_nxt = w_sweep_inc;
               w_down_nxt      = 1'b0;
               if (w_last) w_cnt_rst_n_nxt = 1'b0;
            end
         end
         default: begin
            w_down_nxt      = 1'b0;
            w_cnt_rst_n_nxt = 1'b0;
         end
      endcase
   end

   assign down      = r_down;
   assign cnt_rst_n = r_cnt_rst_n;
   assign err       = r_err;
   assign sweep_cnt = r_sweep_cnt;
   assign busy      = (r_state == c_ST_UP) || (r_state == c_ST_DOWN);
   assign done      = (r_state == c_ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_counter_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_counter_sweep_ctrl
// Purpose  : Sweep sequencer bench with an attached counter and sweep model.
// Revision : 1.0
// ============================================================================
module tb_counter_sweep_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       abort;
   logic [7:0] upper;
   logic [7:0] lower;
   logic [3:0] cycles;
   logic [7:0] count = 8'd0;
   logic       down;
   logic       cnt_rst_n;
   logic       busy;
   logic       done;
   logic       err;
   logic [3:0] sweep_cnt;

   int checks = 0;
   int errors = 0;

   logic [7:0] exp_q[$];
   logic [3:0] exp_s[$];

   counter_sweep_ctrl #(.WIDTH(8), .SWEEP_W(4)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .upper(upper), .lower(lower), .cycles(cycles), .count(count),
      .down(down), .cnt_rst_n(cnt_rst_n), .busy(busy), .done(done),
      .err(err), .sweep_cnt(sweep_cnt)
   );

   always #5 clk = ~clk;

   // The counter being sequenced
   always @(posedge clk) begin
      if (!cnt_rst_n) count <= 8'd0;
      else if (down)  count <= count - 8'd1;
      else            count <= count + 8'd1;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Triangle: rise 1..u, then alternate ramps between u and l.
   task automatic build_model(input int u, input int l, input int c);
      int s = 0;
      exp_q.delete();
      exp_s.delete();
      for (int v = 1; v <= u; v++) begin
         exp_q.push_back(8'(v));
         exp_s.push_back(4'(0));
      end
      for (int r = 0; r < 2 * c - 1; r++) begin
         if (r % 2 == 0) begin
            for (int v = u - 1; v >= l; v--) begin
               if (v == l) s++;
               exp_q.push_back(8'(v));
               exp_s.push_back(4'(s));
            end
         end else begin
            for (int v = l + 1; v <= u; v++) begin
               exp_q.push_back(8'(v));
               exp_s.push_back(4'(s));
            end
         end
      end
   endtask

   task automatic sweep_body(input int u, input int l, input int c);
      int   n;
      logic e_down;
      build_model(u, l, c);
      n = exp_q.size();
      for (int k = 1; k <= n; k++) begin
         tick();
         e_down = 1'b0;
         if (k < n) e_down = (exp_q[k] < exp_q[k-1]);
         checks++;
         if (count !== exp_q[k-1]) begin
            errors++;
            $display("FAIL count E%0d (u=%0d l=%0d c=%0d): got %0d exp %0d", k, u, l, c, count, exp_q[k-1]);
         end
         checks++;
         if (sweep_cnt !== exp_s[k-1]) begin
            errors++;
            $display("FAIL sweep_cnt E%0d: got %0d exp %0d", k, sweep_cnt, exp_s[k-1]);
         end
         checks++;
         if (done !== (k == n)) begin
            errors++;
            $display("FAIL done E%0d: got %b exp %b", k, done, (k == n));
         end
         checks++;
         if (busy !== (k != n)) begin
            errors++;
            $display("FAIL busy E%0d: got %b exp %b", k, busy, (k != n));
         end
         checks++;
         if (down !== e_down) begin
            errors++;
            $display("FAIL down E%0d: got %b exp %b", k, down, e_down);
         end
         checks++;
         if (cnt_rst_n !== (k < n)) begin
            errors++;
            $display("FAIL cnt_rst_n E%0d: got %b exp %b", k, cnt_rst_n, (k < n));
         end
      end
      tick();
      checks++;
      if (count !== 8'd0 || done !== 1'b0 || busy !== 1'b0 || cnt_rst_n !== 1'b0) begin
         errors++;
         $display("FAIL post_done: got count=%0d done=%b busy=%b rst_n=%b exp 0 0 0 0", count, done, busy, cnt_rst_n);
      end
      checks++;
      if (sweep_cnt !== 4'(c)) begin
         errors++;
         $display("FAIL sweep_cnt_hold: got %0d exp %0d", sweep_cnt, c);
      end
   endtask

   task automatic run_sweep(input int u, input int l, input int c, input bit hold, input bit scramble);
      upper  = 8'(u);
      lower  = 8'(l);
      cycles = 4'(c);
      start  = 1'b1;
      tick();
      if (!hold) start = 1'b0;
      checks++;
      if (busy !== 1'b1 || cnt_rst_n !== 1'b1 || down !== 1'b0 || sweep_cnt !== 4'd0 || err !== 1'b0 || count !== 8'd0) begin
         errors++;
         $display("FAIL accept: got busy=%b rst_n=%b down=%b scnt=%0d err=%b count=%0d exp 1 1 0 0 0 0",
                  busy, cnt_rst_n, down, sweep_cnt, err, count);
      end
      if (scramble) begin
         upper  = 8'($urandom);
         lower  = 8'($urandom);
         cycles = 4'($urandom);
      end
      sweep_body(u, l, c);
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; abort = 1'b0;
      upper = 8'd0; lower = 8'd0; cycles = 4'd0;
      repeat (2) tick();
      rst = 1'b0;
      tick();
      checks++;
      if (down !== 1'b0 || cnt_rst_n !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || sweep_cnt !== 4'd0) begin
         errors++;
         $display("FAIL reset: got down=%b rst_n=%b busy=%b done=%b err=%b scnt=%0d exp all 0",
                  down, cnt_rst_n, busy, done, err, sweep_cnt);
      end
      checks++;
      if (count !== 8'd0) begin
         errors++;
         $display("FAIL reset_count: got %0d exp 0", count);
      end
   endtask

   task automatic test_directed();
      run_sweep(5, 2, 2, 1'b0, 1'b0);
      run_sweep(1, 0, 3, 1'b0, 1'b0);
      run_sweep(4, 3, 2, 1'b0, 1'b0);
   endtask

   task automatic test_invalid();
      logic [7:0] iu[3] = '{8'd3, 8'd0, 8'd5};
      logic [7:0] il[3] = '{8'd3, 8'd0, 8'd1};
      logic [3:0] ic[3] = '{4'd2, 4'd2, 4'd0};
      for (int i = 0; i < 3; i++) begin
         upper = iu[i]; lower = il[i]; cycles = ic[i];
         start = 1'b1;
         tick();
         start = 1'b0;
         checks++;
         if (err !== 1'b1 || busy !== 1'b0 || cnt_rst_n !== 1'b0) begin
            errors++;
            $display("FAIL invalid%0d: got err=%b busy=%b rst_n=%b exp 1 0 0", i, err, busy, cnt_rst_n);
         end
         tick();
         checks++;
         if (err !== 1'b0 || busy !== 1'b0 || count !== 8'd0) begin
            errors++;
            $display("FAIL invalid%0d_after: got err=%b busy=%b count=%0d exp 0 0 0", i, err, busy, count);
         end
      end
   endtask

   task automatic test_abort();
      upper = 8'd10; lower = 8'd0; cycles = 4'd4;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (6) tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      checks++;
      if (count !== 8'd7 || busy !== 1'b0 || cnt_rst_n !== 1'b0 || down !== 1'b0 || done !== 1'b0 || sweep_cnt !== 4'd0) begin
         errors++;
         $display("FAIL abort: got count=%0d busy=%b rst_n=%b down=%b done=%b scnt=%0d exp 7 0 0 0 0 0",
                  count, busy, cnt_rst_n, down, done, sweep_cnt);
      end
      tick();
      checks++;
      if (count !== 8'd0 || done !== 1'b0) begin
         errors++;
         $display("FAIL abort_after: got count=%0d done=%b exp 0 0", count, done);
      end
      run_sweep(3, 1, 1, 1'b0, 1'b0);
   endtask

   task automatic test_async_reset();
      upper = 8'd6; lower = 8'd0; cycles = 4'd2;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (8) tick();
      checks++;
      if (down !== 1'b1 || count !== 8'd4) begin
         errors++;
         $display("FAIL pre_rst: got down=%b count=%0d exp 1 4", down, count);
      end
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if (cnt_rst_n !== 1'b0 || down !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || sweep_cnt !== 4'd0) begin
         errors++;
         $display("FAIL async_rst: got rst_n=%b down=%b busy=%b done=%b scnt=%0d exp all 0",
                  cnt_rst_n, down, busy, done, sweep_cnt);
      end
      tick();
      checks++;
      if (count !== 8'd0) begin
         errors++;
         $display("FAIL async_rst_count: got %0d exp 0", count);
      end
      #2;
      rst = 1'b0;
   endtask

   task automatic test_start_held();
      run_sweep(2, 0, 1, 1'b1, 1'b0);
      tick();
      checks++;
      if (busy !== 1'b1 || cnt_rst_n !== 1'b1 || count !== 8'd0) begin
         errors++;
         $display("FAIL restart: got busy=%b rst_n=%b count=%0d exp 1 1 0", busy, cnt_rst_n, count);
      end
      start = 1'b0;
      sweep_body(2, 0, 1);
   endtask

   task automatic test_random();
      int u, l, c;
      for (int it = 0; it < 20; it++) begin
         u = int'($urandom_range(20, 1));
         l = int'($urandom_range(u - 1, 0));
         c = int'($urandom_range(4, 1));
         run_sweep(u, l, c, 1'b0, 1'b1);
         repeat ($urandom_range(2, 0)) tick();
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_invalid();
      test_abort();
      test_async_reset();
      test_start_held();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
